lbp_host_mem: RTL and testbench
===============================

// Module: lbp_host_mem
// PURPOSE
//  Host-side counterpart of the LBP engine: owns the 128x128 gray image RAM and the LBP result RAM.
//  Serves gray_addr/gray_req reads with zero-latency gray_data, and captures lbp_addr/lbp_data writes.
//  Tracks frame progress until the engine raises finish, then exposes results on a readback port.
//  Sits between the system loader / readback logic and the LBP engine.
// PARAMETERS
//  IMG_W  128  image width = height, in pixels; address = row*IMG_W + col
//  AW     14   address width; must equal log2(IMG_W*IMG_W)
//  DW     8    pixel / LBP code width
// PORTS
//  clk            in   1   clock; every register updates on its rising edge
//  reset          in   1   asynchronous, active-high reset
//  img_we         in   1   image load write strobe
//  img_waddr      in   AW  image load address
//  img_wdata      in   DW  image load pixel
//  img_load_done  in   1   1-cycle pulse: image fully loaded
//  gray_ready     out  1   image available to the LBP engine
//  gray_req       in   1   engine read enable
//  gray_addr      in   AW  engine read address
//  gray_data      out  DW  pixel at gray_addr, same cycle
//  lbp_valid      in   1   engine result write strobe
//  lbp_addr       in   AW  result address
//  lbp_data       in   DW  result code
//  finish         in   1   engine end-of-frame, level
//  res_raddr      in   AW  result readback address
//  res_rdata      out  DW  result readback data, 1-cycle latency
//  wr_count       out  AW+1  number of result writes captured this frame
//  done           out  1   frame complete (DONE state)
//  err            out  1   sticky protocol error flag
// BEHAVIOUR
//  Reset: state=IDLE; gray_ready=0, done=0, err=0, wr_count=0, res_rdata=0. RAM contents not cleared.
//  Reset mid-frame aborts immediately; RAM contents stay as last written.
//  FSM: IDLE -> LOAD on img_we (that write is performed).
//   LOAD: each img_we writes img_wdata to image RAM. img_load_done -> STREAM. img_we and
//     img_load_done in same cycle: write performed, then transition.
//   STREAM: gray_ready=1 (registered, high the cycle after entry). finish=1 -> DONE.
//   DONE: gray_ready=0, done=1. img_we -> LOAD: write performed, wr_count and err cleared.
//  gray_data = image_ram[gray_addr] when gray_req=1, else 8'h00.
//   Combinational read: address presented at edge k yields data sampled at edge k+1.
//  Result capture: lbp_valid=1 in STREAM or DONE writes lbp_data to result RAM at lbp_addr.
//   wr_count += 1 on each capture; saturates at 2^AW.
//   Write in the same cycle finish first rises is captured.
//  err set (sticky until next frame or reset) on any of:
//   - img_we in STREAM; write is dropped.
//   - lbp_valid in IDLE/LOAD; write is dropped.
//   - lbp_addr on image border (row or col 0 or IMG_W-1) in STREAM/DONE; write is dropped.
//  Readback: res_rdata is registered, valid 1 cycle after res_raddr.
//   Border addresses return 8'h00 regardless of RAM contents.
//   Read/write collision on the same address returns old data.
//  Address widths are unsigned; no wrap logic needed (AW covers IMG_W^2 exactly).
// STRUCTURE
//  Package lbp_pkg: state enum {IDLE,LOAD,STREAM,DONE}, IMG_W/AW/DW constants,
//   function is_border(addr) -> 1 if row or col is 0 or IMG_W-1.
//  Sub-module lbp_host_ram (1 sync write port, 1 async read port, DEPTH/DW params), instantiated twice:
//   image RAM and result RAM. Result readback register and border masking live in the top level.
// TESTING
//  1 Reset mid-LOAD -> gray_ready=0, done=0, err=0, wr_count=0 the cycle reset asserts.
//  2 Load pixel addr 129 = 8'h5A, img_load_done; gray_req=1, gray_addr=129 ->
//    gray_data=8'h5A same cycle; gray_ready=1 the cycle after entering STREAM; gray_req=0 -> gray_data=0.
//  3 STREAM: lbp_valid with lbp_addr=130, lbp_data=8'hC3; later res_raddr=130 -> res_rdata=8'hC3
//    one cycle later; wr_count=1.
//  4 lbp_valid with lbp_addr=0 (border) -> err=1, wr_count unchanged; res_raddr=0 -> 8'h00.
//  5 Full 126x126 interior sweep then finish=1, with a write in the finish cycle -> wr_count=15876,
//    done=1, gray_ready=0.
//  6 DONE then img_we -> LOAD, wr_count=0, err=0; img_we during STREAM -> err=1, pixel unchanged.

Source files
------------

// File: rtl/lbp_pkg.sv
// Shared definitions for the LBP host memory block.
// Contents:
//   IMG_W, AW, DW, CW   image geometry and data widths (CW = column-index width)
//   state_e             host FSM states
//   is_border()         true when an address lies on the outermost pixel ring
package lbp_pkg;

    localparam int unsigned IMG_W = 128;
    localparam int unsigned AW    = 14;
    localparam int unsigned DW    = 8;
    localparam int unsigned CW    = $clog2(IMG_W);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StStream,
        StDone
    } state_e;

    // Address is row*IMG_W + col with IMG_W a power of two, so row/col are plain bit fields.
    function automatic logic is_border(input logic [AW-1:0] addr);
        logic [CW-1:0] row;
        logic [CW-1:0] col;
        row = addr[AW-1:CW];
        col = addr[CW-1:0];
        return (row == '0) || (col == '0) || (row == CW'(IMG_W - 1)) || (col == CW'(IMG_W - 1));
    endfunction

endpackage

// File: rtl/lbp_host_mem_if.sv
// Bus between the loader / LBP engine / readback logic and the host memory.
// Ports (as seen from the memory, modport slave):
//   in : img_we, img_waddr, img_wdata, img_load_done     image load
//   in : gray_req, gray_addr   out: gray_ready, gray_data    engine pixel reads
//   in : lbp_valid, lbp_addr, lbp_data, finish              engine result writes
//   in : res_raddr             out: res_rdata                result readback
//   out: wr_count, done, err                                 frame status
interface lbp_host_mem_if
    import lbp_pkg::*;
();

    logic          img_we;
    logic [AW-1:0] img_waddr;
    logic [DW-1:0] img_wdata;
    logic          img_load_done;
    logic          gray_ready;
    logic          gray_req;
    logic [AW-1:0] gray_addr;
    logic [DW-1:0] gray_data;
    logic          lbp_valid;
    logic [AW-1:0] lbp_addr;
    logic [DW-1:0] lbp_data;
    logic          finish;
    logic [AW-1:0] res_raddr;
    logic [DW-1:0] res_rdata;
    logic [AW:0]   wr_count;
    logic          done;
    logic          err;

    modport master (
        output img_we, img_waddr, img_wdata, img_load_done,
        output gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish, res_raddr,
        input  gray_ready, gray_data, res_rdata, wr_count, done, err
    );

    modport slave (
        input  img_we, img_waddr, img_wdata, img_load_done,
        input  gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish, res_raddr,
        output gray_ready, gray_data, res_rdata, wr_count, done, err
    );

endinterface

// File: rtl/lbp_host_ram.sv
// Simple RAM: one synchronous write port, one asynchronous read port. Not reset.
// Ports:
//   clk_i    clock
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write data
//   raddr_i  read address
//   rdata_o  read data (combinational)
module lbp_host_ram #(
    parameter int unsigned Depth = 16384,
    parameter int unsigned Width = 8,
    parameter int unsigned Aw    = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [Aw-1:0]    waddr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic [Aw-1:0]    raddr_i,
    output logic [Width-1:0] rdata_o
);

    logic [Width-1:0] mem [Depth];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/lbp_host_mem.sv
// Host-side memory for the LBP engine: image RAM served to the engine, result RAM captured
// from it, frame-progress FSM and result readback.
// Ports:
//   clk    clock, rising edge
//   reset  asynchronous, active-high
//   bus    lbp_host_mem_if.slave (load, engine read/write, readback, status)
module lbp_host_mem
    import lbp_pkg::*;
(
    input logic           clk,
    input logic           reset,
    lbp_host_mem_if.slave bus
);

    localparam int unsigned    CNTW   = AW + 1;
    localparam logic [AW:0]    WR_MAX = {1'b1, {AW{1'b0}}};

    state_e        state;
    logic          gray_ready;
    logic          done;
    logic          err;
    logic [AW:0]   wr_count;
    logic [AW:0]   wr_count_d;
    logic [DW-1:0] res_rdata;

    logic          img_we_ok;
    logic          res_phase;
    logic          res_we;
    logic          new_frame;
    logic          err_set;
    logic [DW-1:0] img_rdata;
    logic [DW-1:0] res_ram_rdata;

    always_comb begin
        res_phase = (state == StStream) || (state == StDone);
        img_we_ok = bus.img_we && (state != StStream);
        res_we    = bus.lbp_valid && res_phase && !is_border(bus.lbp_addr);
        new_frame = bus.img_we && (state == StDone);
        err_set   = (bus.img_we && (state == StStream))
                  || (bus.lbp_valid && !res_phase)
                  || (bus.lbp_valid && res_phase && is_border(bus.lbp_addr));

        // A new frame restarts the count; a capture in that same cycle still counts.
        wr_count_d = new_frame ? '0 : wr_count;
        if (res_we && (wr_count_d != WR_MAX)) begin
            wr_count_d = wr_count_d + CNTW'(1);
        end
    end

    lbp_host_ram #(
        .Depth (IMG_W * IMG_W),
        .Width (DW)
    ) u_img_ram (
        .clk_i   (clk),
        .we_i    (img_we_ok),
        .waddr_i (bus.img_waddr),
        .wdata_i (bus.img_wdata),
        .raddr_i (bus.gray_addr),
        .rdata_o (img_rdata)
    );

    lbp_host_ram #(
        .Depth (IMG_W * IMG_W),
        .Width (DW)
    ) u_res_ram (
        .clk_i   (clk),
        .we_i    (res_we),
        .waddr_i (bus.lbp_addr),
        .wdata_i (bus.lbp_data),
        .raddr_i (bus.res_raddr),
        .rdata_o (res_ram_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= StIdle;
            gray_ready <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            wr_count   <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (bus.img_we) state <= StLoad;
                end
                StLoad: begin
                    if (bus.img_load_done) begin
                        state      <= StStream;
                        gray_ready <= 1'b1;
                    end
                end
                StStream: begin
                    if (bus.finish) begin
                        state      <= StDone;
                        gray_ready <= 1'b0;
                        done       <= 1'b1;
                    end
                end
                StDone: begin
                    if (bus.img_we) begin
                        state <= StLoad;
                        done  <= 1'b0;
                    end
                end
                default: state <= StIdle;
            endcase
            err      <= (err && !new_frame) || err_set;
            wr_count <= wr_count_d;
        end
    end

    // RAM read happens before the same-edge write lands, so a collision returns old data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_rdata <= '0;
        end else begin
            res_rdata <= is_border(bus.res_raddr) ? '0 : res_ram_rdata;
        end
    end

    assign bus.gray_ready = gray_ready;
    assign bus.gray_data  = bus.gray_req ? img_rdata : '0;
    assign bus.res_rdata  = res_rdata;
    assign bus.wr_count   = wr_count;
    assign bus.done       = done;
    assign bus.err        = err;

endmodule

// File: tb/tb_lbp_host_mem.sv
module tb_lbp_host_mem;
    import lbp_pkg::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    lbp_host_mem_if bus ();

    lbp_host_mem dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.img_we        = 1'b0;
        bus.img_waddr     = '0;
        bus.img_wdata     = '0;
        bus.img_load_done = 1'b0;
        bus.gray_req      = 1'b0;
        bus.gray_addr     = '0;
        bus.lbp_valid     = 1'b0;
        bus.lbp_addr      = '0;
        bus.lbp_data      = '0;
        bus.finish        = 1'b0;
        bus.res_raddr     = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        reset = 1'b0;
        tick();
        // enter LOAD, then provoke err with a result write during LOAD
        bus.img_we = 1'b1; bus.img_waddr = 14'd5; bus.img_wdata = 8'h11;
        tick();
        bus.img_we = 1'b0; bus.lbp_valid = 1'b1; bus.lbp_addr = 14'd130;
        tick();
        bus.lbp_valid = 1'b0;
        n_checks++;
        if (bus.err !== 1'b1) begin
            n_fail++; $display("FAIL load_lbp_err: got %b expected 1", bus.err);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (bus.gray_ready !== 1'b0) begin
            n_fail++; $display("FAIL rst_gray_ready: got %b expected 0", bus.gray_ready);
        end
        n_checks++;
        if (bus.done !== 1'b0) begin
            n_fail++; $display("FAIL rst_done: got %b expected 0", bus.done);
        end
        n_checks++;
        if (bus.err !== 1'b0) begin
            n_fail++; $display("FAIL rst_err: got %b expected 0", bus.err);
        end
        n_checks++;
        if (bus.wr_count !== 15'd0) begin
            n_fail++; $display("FAIL rst_wr_count: got %0d expected 0", bus.wr_count);
        end
        n_checks++;
        if (bus.res_rdata !== 8'h00) begin
            n_fail++; $display("FAIL rst_res_rdata: got %h expected 00", bus.res_rdata);
        end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_gray_read();
        bus.img_we = 1'b1; bus.img_waddr = 14'd129; bus.img_wdata = 8'h5A;
        tick();
        bus.img_waddr = 14'd300; bus.img_wdata = 8'hB4;
        tick();
        bus.img_we = 1'b0; bus.img_load_done = 1'b1;
        n_checks++;
        if (bus.gray_ready !== 1'b0) begin
            n_fail++; $display("FAIL gray_ready_in_load: got %b expected 0", bus.gray_ready);
        end
        tick();
        bus.img_load_done = 1'b0;
        n_checks++;
        if (bus.gray_ready !== 1'b1) begin
            n_fail++; $display("FAIL gray_ready_stream: got %b expected 1", bus.gray_ready);
        end
        bus.gray_req = 1'b1; bus.gray_addr = 14'd129;
        #1;
        n_checks++;
        if (bus.gray_data !== 8'h5A) begin
            n_fail++; $display("FAIL gray_data_129: got %h expected 5a", bus.gray_data);
        end
        bus.gray_addr = 14'd300;
        #1;
        n_checks++;
        if (bus.gray_data !== 8'hB4) begin
            n_fail++; $display("FAIL gray_data_300: got %h expected b4", bus.gray_data);
        end
        bus.gray_req = 1'b0;
        #1;
        n_checks++;
        if (bus.gray_data !== 8'h00) begin
            n_fail++; $display("FAIL gray_data_noreq: got %h expected 00", bus.gray_data);
        end
        tick();
    endtask

    task automatic test_result_write();
        bus.lbp_valid = 1'b1; bus.lbp_addr = 14'd130; bus.lbp_data = 8'hC3;
        tick();
        bus.lbp_valid = 1'b0;
        n_checks++;
        if (bus.wr_count !== 15'd1) begin
            n_fail++; $display("FAIL wr_count_one: got %0d expected 1", bus.wr_count);
        end
        tick();
        bus.res_raddr = 14'd130;
        tick();
        n_checks++;
        if (bus.res_rdata !== 8'hC3) begin
            n_fail++; $display("FAIL res_rdata_130: got %h expected c3", bus.res_rdata);
        end
        // collision: read and write 130 in the same cycle returns the old code
        bus.lbp_valid = 1'b1; bus.lbp_data = 8'h99;
        tick();
        bus.lbp_valid = 1'b0;
        n_checks++;
        if (bus.res_rdata !== 8'hC3) begin
            n_fail++; $display("FAIL collision_old: got %h expected c3", bus.res_rdata);
        end
        tick();
        n_checks++;
        if (bus.res_rdata !== 8'h99) begin
            n_fail++; $display("FAIL collision_new: got %h expected 99", bus.res_rdata);
        end
        n_checks++;
        if (bus.wr_count !== 15'd2) begin
            n_fail++; $display("FAIL wr_count_two: got %0d expected 2", bus.wr_count);
        end
    endtask

    task automatic test_border();
        logic [AW-1:0] border_addrs [4];
        border_addrs[0] = 14'd0;
        border_addrs[1] = 14'd127;
        border_addrs[2] = 14'd128;
        border_addrs[3] = 14'd255;
        n_checks++;
        if (bus.err !== 1'b0) begin
            n_fail++; $display("FAIL err_before_border: got %b expected 0", bus.err);
        end
        bus.lbp_valid = 1'b1; bus.lbp_addr = 14'd0; bus.lbp_data = 8'hFF;
        tick();
        bus.lbp_valid = 1'b0;
        n_checks++;
        if (bus.err !== 1'b1) begin
            n_fail++; $display("FAIL border_err: got %b expected 1", bus.err);
        end
        n_checks++;
        if (bus.wr_count !== 15'd2) begin
            n_fail++; $display("FAIL border_wr_count: got %0d expected 2", bus.wr_count);
        end
        for (int i = 0; i < 4; i++) begin
            bus.res_raddr = border_addrs[i];
            tick();
            n_checks++;
            if (bus.res_rdata !== 8'h00) begin
                n_fail++;
                $display("FAIL border_read_%0d: got %h expected 00", border_addrs[i], bus.res_rdata);
            end
        end
    endtask

    task automatic test_sweep();
        logic [AW-1:0] probe_addr [4];
        logic [DW-1:0] probe_exp  [4];
        reset = 1'b1;
        idle_inputs();
        tick();
        reset = 1'b0;
        bus.img_we = 1'b1; bus.img_waddr = 14'd129; bus.img_wdata = 8'h5A;
        tick();
        bus.img_we = 1'b0; bus.img_load_done = 1'b1;
        tick();
        bus.img_load_done = 1'b0;
        for (int r = 1; r <= 126; r++) begin
            for (int c = 1; c <= 126; c++) begin
                bus.lbp_valid = 1'b1;
                bus.lbp_addr  = AW'(r * 128 + c);
                bus.lbp_data  = DW'(r + c);
                bus.finish    = (r == 126) && (c == 126);
                tick();
            end
        end
        bus.lbp_valid = 1'b0;
        bus.finish    = 1'b0;
        n_checks++;
        if (bus.wr_count !== 15'd15876) begin
            n_fail++; $display("FAIL sweep_wr_count: got %0d expected 15876", bus.wr_count);
        end
        n_checks++;
        if (bus.done !== 1'b1) begin
            n_fail++; $display("FAIL sweep_done: got %b expected 1", bus.done);
        end
        n_checks++;
        if (bus.gray_ready !== 1'b0) begin
            n_fail++; $display("FAIL sweep_gray_ready: got %b expected 0", bus.gray_ready);
        end
        n_checks++;
        if (bus.err !== 1'b0) begin
            n_fail++; $display("FAIL sweep_err: got %b expected 0", bus.err);
        end
        // a capture while in DONE is still accepted
        bus.lbp_valid = 1'b1; bus.lbp_addr = 14'd645; bus.lbp_data = 8'hAA;
        tick();
        bus.lbp_valid = 1'b0;
        n_checks++;
        if (bus.wr_count !== 15'd15877) begin
            n_fail++; $display("FAIL done_wr_count: got %0d expected 15877", bus.wr_count);
        end
        probe_addr[0] = 14'd129;   probe_exp[0] = 8'h02;
        probe_addr[1] = 14'd16254; probe_exp[1] = 8'hFC;
        probe_addr[2] = 14'd8195;  probe_exp[2] = 8'h43;
        probe_addr[3] = 14'd645;   probe_exp[3] = 8'hAA;
        for (int i = 0; i < 4; i++) begin
            bus.res_raddr = probe_addr[i];
            tick();
            n_checks++;
            if (bus.res_rdata !== probe_exp[i]) begin
                n_fail++;
                $display("FAIL sweep_read_%0d: got %h expected %h", probe_addr[i], bus.res_rdata,
                         probe_exp[i]);
            end
        end
    endtask

    task automatic test_new_frame();
        bus.lbp_valid = 1'b1; bus.lbp_addr = 14'd0;
        tick();
        bus.lbp_valid = 1'b0;
        n_checks++;
        if (bus.err !== 1'b1) begin
            n_fail++; $display("FAIL done_border_err: got %b expected 1", bus.err);
        end
        bus.img_we = 1'b1; bus.img_waddr = 14'd129; bus.img_wdata = 8'h3C;
        tick();
        bus.img_we = 1'b0;
        n_checks++;
        if (bus.wr_count !== 15'd0) begin
            n_fail++; $display("FAIL frame_wr_count: got %0d expected 0", bus.wr_count);
        end
        n_checks++;
        if (bus.err !== 1'b0) begin
            n_fail++; $display("FAIL frame_err: got %b expected 0", bus.err);
        end
        n_checks++;
        if (bus.done !== 1'b0) begin
            n_fail++; $display("FAIL frame_done: got %b expected 0", bus.done);
        end
        bus.img_load_done = 1'b1;
        tick();
        bus.img_load_done = 1'b0;
        n_checks++;
        if (bus.gray_ready !== 1'b1) begin
            n_fail++; $display("FAIL frame_gray_ready: got %b expected 1", bus.gray_ready);
        end
        bus.img_we = 1'b1; bus.img_waddr = 14'd129; bus.img_wdata = 8'h11;
        tick();
        bus.img_we = 1'b0;
        n_checks++;
        if (bus.err !== 1'b1) begin
            n_fail++; $display("FAIL stream_we_err: got %b expected 1", bus.err);
        end
        bus.gray_req = 1'b1; bus.gray_addr = 14'd129;
        #1;
        n_checks++;
        if (bus.gray_data !== 8'h3C) begin
            n_fail++; $display("FAIL stream_we_dropped: got %h expected 3c", bus.gray_data);
        end
        bus.gray_req = 1'b0;
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_gray_read();
        test_result_write();
        test_border();
        test_sweep();
        test_new_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
